lag_traffic_sink: RTL
=====================

LAG_TRAFFIC_SINK -- requirements
Module: LAG_traffic_sink

Interface
REQ-001 SHALL have parameter np, default 4: number of physical channels on network exit; only channel 0 is used.
REQ-002 SHALL have parameter xpos, default 0: mesh X coordinate of the attached router.
REQ-003 SHALL have parameter ypos, default 0: mesh Y coordinate of the attached router.
REQ-004 SHALL have parameter packet_length, default 3: flits per packet (>=1).
REQ-005 SHALL have parameter stall_period, default 0: ready is deasserted one cycle in every stall_period cycles; 0 means always ready.
REQ-006 SHALL have port clk, input, 1: single clock, rising-edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port flit_in, input, flit_t: ejected flit; control.valid qualifies it.
REQ-009 SHALL have port ready_o, output, np: bit 0 is the sink-ready flow control; bits np-1:1 are tied 0.
REQ-010 SHALL have ports flits_received_o and packets_received_o, output, 32 each: accepted-flit and completed-packet counts.
REQ-011 SHALL have port latency_sum_o, output, 64: summed packet latency in cycles.
REQ-012 SHALL have ports error_o, output, 1, and error_code_o, output, 3: sticky error flag and first-error code.

Function
REQ-013 SHALL accept a flit only in a cycle where flit_in.control.valid and ready_o[0] are both 1.
REQ-014 SHALL keep a 32-bit free-running sys_time, starting at 0 after reset and wrapping modulo 2^32.
REQ-015 SHALL drive ready_o[0] low when stall_period>0 and sys_time mod stall_period == stall_period-1, and high otherwise.
REQ-016 SHALL implement FSM IDLE (expect head) and BODY (expect body or tail), with a 16-bit flit_count.
REQ-017 In IDLE, an accepted head SHALL latch debug.packet_id, debug.inject_time and debug.xsrc/ysrc, and set flit_count=1; it SHALL go to BODY unless packet_length==1.
REQ-018 With packet_length==1, an accepted flit with head=1 and tail=1 SHALL complete the packet and leave the FSM in IDLE.
REQ-019 In BODY, each accepted flit SHALL increment flit_count; when the count reaches packet_length the flit SHALL carry tail=1, complete the packet and return the FSM to IDLE.
REQ-020 On packet completion, packets_received_o SHALL increment and latency_sum_o SHALL add (sys_time - inject_time), both visible one cycle after the tail is accepted.
REQ-021 flits_received_o SHALL increment on every accepted flit, including erroneous flits; all counters SHALL wrap.
REQ-022 SHALL detect the following errors, each as a code:
- 1: non-head flit in IDLE
- 2: head in BODY
- 3: tail flag missing or early (tail=1 with flit_count != packet_length)
- 4: debug.xdest/ydest != xpos/ypos
- 5: debug.flit_id != flit_count
- 6: packet_id or source changes within a packet
- 7: valid asserted while ready_o[0]==0
REQ-023 error_o SHALL latch 1 permanently; error_code_o SHALL hold the first code recorded.
REQ-024 If several errors occur in one cycle, error_code_o SHALL take the lowest code.
REQ-025 On error, the FSM SHALL resynchronise: an erroneous head starts a new packet (BODY), any other erroneous flit returns it to IDLE, and the broken packet SHALL NOT be counted.
REQ-026 A flit with valid=1 while ready_o[0]==0 SHALL NOT be accepted.

Reset
REQ-027 While rst_n==0, regardless of clk: FSM=IDLE, all counters, sys_time and latency_sum_o = 0, error_o=0, error_code_o=0, ready_o=0.
REQ-028 ready_o[0] SHALL rise in the first rising clk edge after rst_n deasserts.
REQ-029 Reset asserted mid-packet SHALL discard the partial packet without raising an error.

Configuration
REQ-030 With macro LAG_SINK_LATENCY_EN defined, latency_sum_o SHALL accumulate per REQ-020, and a 32-bit max_latency_o output SHALL hold the largest single-packet latency seen.
REQ-031 Without LAG_SINK_LATENCY_EN, latency_sum_o SHALL be tied 0, max_latency_o SHALL be absent, and no latency arithmetic SHALL be synthesised.

Verification
REQ-032 Stimulus: packet_length=3, one packet to (0,0) with inject_time=10, tail accepted at sys_time=25 -> packets_received_o=1, flits_received_o=3, latency_sum_o=15, error_o=0.
REQ-033 Stimulus: body flit with flit_id=1 in IDLE -> error_o=1, error_code_o=1, FSM stays IDLE, packets_received_o unchanged.
REQ-034 Stimulus: stall_period=4 -> ready_o[0] low at sys_time 3,7,11; a valid flit at sys_time 3 -> not counted, error_code_o=7.
REQ-035 Stimulus: packet_length=1, 5 back-to-back head+tail flits -> packets_received_o=5, error_o=0.
REQ-036 Stimulus: head with xdest=1 at sink xpos=0, then a second head mid-packet -> error_code_o=4 (first error retained), FSM in BODY after the second head.
REQ-037 Stimulus: rst_n pulsed low after 2 of 3 flits, then a full packet -> no error, packets_received_o=1.

Source files
------------

// File: rtl/lag_traffic_sink.sv
// Ejection-side traffic sink for a LAG mesh router: checks packet framing and counts flits, packets and latency.
// Define LAG_SINK_LATENCY_EN to build the latency accumulator and the max_latency_o port.
package lag_sink_pkg;
    typedef struct packed {
        logic valid;
        logic head;
        logic tail;
    } flit_control_t;

    typedef struct packed {
        logic [15:0] packet_id;
        logic [15:0] flit_id;
        logic [31:0] inject_time;
        logic [3:0]  xsrc;
        logic [3:0]  ysrc;
        logic [3:0]  xdest;
        logic [3:0]  ydest;
    } flit_debug_t;

    typedef struct packed {
        flit_control_t control;
        logic [31:0]   data;
        flit_debug_t   debug;
    } flit_t;
endpackage

module lag_traffic_sink
    import lag_sink_pkg::*;
#(
    parameter int np            = 4,
    parameter int xpos          = 0,
    parameter int ypos          = 0,
    parameter int packet_length = 3,
    parameter int stall_period  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  flit_t           flit_in,
    output logic [np-1:0]   ready_o,
    output logic [31:0]     flits_received_o,
    output logic [31:0]     packets_received_o,
    output logic [63:0]     latency_sum_o,
`ifdef LAG_SINK_LATENCY_EN
    output logic [31:0]     max_latency_o,
`endif
    output logic            error_o,
    output logic [2:0]      error_code_o
);

    localparam logic [0:0]  ST_IDLE   = 1'b0;
    localparam logic [0:0]  ST_BODY   = 1'b1;
    localparam logic [15:0] PKT_LEN   = 16'(packet_length);
    localparam logic [3:0]  X_POS     = 4'(xpos);
    localparam logic [3:0]  Y_POS     = 4'(ypos);
    localparam logic [31:0] PHASE_MAX = (stall_period > 0) ? 32'(stall_period - 1) : 32'd0;

    logic [0:0]  state;
    logic [15:0] flit_count;
    logic [15:0] cnt_next;
    logic [15:0] pkt_id_r;
    logic [3:0]  xsrc_r;
    logic [3:0]  ysrc_r;
    logic [31:0] sys_time;
    logic [31:0] phase;
    logic [31:0] flits_r;
    logic [31:0] pkts_r;
    logic        run;
    logic        rdy;
    logic        accept;
    logic        is_last;
    logic        err_now;
    logic        complete;
    logic        error_r;
    logic [2:0]  code_r;
    logic [7:1]  flags;

    function automatic logic [2:0] first_code(input logic [7:1] f);
        logic [2:0] code;
        code = 3'd0;
        for (int k = 7; k >= 1; k--) begin
            if (f[k]) code = 3'(k);
        end
        return code;
    endfunction

    // phase tracks sys_time mod stall_period without a divider; it restarts when sys_time wraps
    assign rdy     = run && !(stall_period > 0 && phase == PHASE_MAX);
    assign ready_o = {{(np-1){1'b0}}, rdy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 1'b0;
            sys_time <= '0;
            phase    <= '0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            sys_time <= sys_time + 32'd1;
            if (sys_time == '1 || phase == PHASE_MAX) phase <= '0;
            else                                      phase <= phase + 32'd1;
        end
    end

    always_comb begin
        accept   = flit_in.control.valid && rdy;
        cnt_next = (state == ST_IDLE || flit_in.control.head) ? 16'd1 : flit_count + 16'd1;
        is_last  = (cnt_next == PKT_LEN);
        flags    = '0;
        flags[1] = accept && state == ST_IDLE && !flit_in.control.head;
        flags[2] = accept && state == ST_BODY && flit_in.control.head;
        flags[3] = accept && (flit_in.control.tail != is_last);
        flags[4] = accept && (flit_in.debug.xdest != X_POS || flit_in.debug.ydest != Y_POS);
        flags[5] = accept && (flit_in.debug.flit_id != cnt_next);
        flags[6] = accept && state == ST_BODY &&
                   (flit_in.debug.packet_id != pkt_id_r ||
                    flit_in.debug.xsrc != xsrc_r || flit_in.debug.ysrc != ysrc_r);
        flags[7] = flit_in.control.valid && !rdy;
        err_now  = |flags[6:1];
        complete = accept && !err_now && is_last;
    end

    // any head restarts a packet, so an erroneous head resynchronises into BODY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            flit_count <= '0;
            pkt_id_r   <= '0;
            xsrc_r     <= '0;
            ysrc_r     <= '0;
        end else if (accept) begin
            if (flit_in.control.head) begin
                state      <= (PKT_LEN == 16'd1) ? ST_IDLE : ST_BODY;
                flit_count <= 16'd1;
                pkt_id_r   <= flit_in.debug.packet_id;
                xsrc_r     <= flit_in.debug.xsrc;
                ysrc_r     <= flit_in.debug.ysrc;
            end else if (err_now) begin
                state <= ST_IDLE;
            end else begin
                flit_count <= cnt_next;
                state      <= is_last ? ST_IDLE : ST_BODY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flits_r <= '0;
            pkts_r  <= '0;
            error_r <= 1'b0;
            code_r  <= 3'd0;
        end else begin
            if (accept)   flits_r <= flits_r + 32'd1;
            if (complete) pkts_r  <= pkts_r + 32'd1;
            if (!error_r && |flags) begin
                error_r <= 1'b1;
                code_r  <= first_code(flags);
            end
        end
    end

    assign flits_received_o   = flits_r;
    assign packets_received_o = pkts_r;
    assign error_o            = error_r;
    assign error_code_o       = code_r;

`ifdef LAG_SINK_LATENCY_EN
    logic [31:0] inject_r;
    logic [31:0] lat_now;
    logic [63:0] lat_sum_r;
    logic [31:0] lat_max_r;
    logic        unused_bits;

    // a single-flit packet completes in IDLE, so its inject time comes straight off the flit
    assign lat_now = sys_time - ((state == ST_IDLE) ? flit_in.debug.inject_time : inject_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inject_r  <= '0;
            lat_sum_r <= '0;
            lat_max_r <= '0;
        end else begin
            if (accept && flit_in.control.head) inject_r <= flit_in.debug.inject_time;
            if (complete) begin
                lat_sum_r <= lat_sum_r + {32'd0, lat_now};
                if (lat_now > lat_max_r) lat_max_r <= lat_now;
            end
        end
    end

    assign latency_sum_o = lat_sum_r;
    assign max_latency_o = lat_max_r;
    assign unused_bits   = ^flit_in.data;
`else
    logic unused_bits;
    assign latency_sum_o = '0;
    assign unused_bits   = ^{flit_in.data, flit_in.debug.inject_time};
`endif

endmodule
